// File: rtl/sw_sram_arbiter.sv
// sw_sram_arbiter: shares one single-port score/sequence SRAM between the
// sequence loader (port 0) and the PE-array fetch/writeback path (port 1).
// Round-robin arbitration with a bounded burst lock; read data is returned
// one cycle after the grant, tagged to the port that issued the read.
module sw_sram_arbiter #(
    parameter int WORD_WIDTH = 128,
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic                  p0_lock,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [WORD_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [WORD_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic                  p1_lock,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [WORD_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [WORD_WIDTH-1:0] p1_rdata,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [WORD_WIDTH-1:0] sram_d,
    input  logic [WORD_WIDTH-1:0] sram_q
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Registered arbitration and read-return state
    logic             prio;
    logic             owner;
    logic [CNT_W-1:0] burst_cnt;
    logic             rd_pend;
    logic             rd_port;

    // Next-state values
    logic             prio_n;
    logic             owner_n;
    logic [CNT_W-1:0] burst_cnt_n;
    logic             rd_pend_n;
    logic             rd_port_n;

    // Combinational grant decision
    logic gnt0;
    logic gnt1;
    logic any_gnt;
    logic win;
    logic win_we;
    logic owner_lock;
    logic lock_hold;

    // Grant decision: a lone requester always wins; on contention the locked
    // owner keeps the port until its burst budget runs out, otherwise prio wins.
    // Nothing is granted while reset is held.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        owner_lock = owner ? p1_lock : p0_lock;
        lock_hold  = owner_lock && (burst_cnt < CNT_MAX);
        if (!rst) begin
            if (p0_req && p1_req) begin
                if (lock_hold) begin
                    gnt0 = ~owner;
                    gnt1 = owner;
                end else begin
                    gnt0 = ~prio;
                    gnt1 = prio;
                end
            end else begin
                gnt0 = p0_req;
                gnt1 = p1_req;
            end
        end
        any_gnt = gnt0 | gnt1;
        win     = gnt1;
        win_we  = gnt1 ? p1_we : p0_we;
    end

    // Next-state: a nonzero burst_cnt doubles as "granted last cycle", since
    // it is cleared by reset and by every idle cycle.
    always_comb begin
        prio_n      = prio;
        owner_n     = owner;
        burst_cnt_n = burst_cnt;
        rd_pend_n   = 1'b0;
        rd_port_n   = rd_port;
        if (any_gnt) begin
            owner_n = win;
            prio_n  = ~win;
            if ((win == owner) && (burst_cnt != '0)) begin
                burst_cnt_n = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + CNT_ONE;
            end else begin
                burst_cnt_n = CNT_ONE;
            end
            if (!win_we) begin
                rd_pend_n = 1'b1;
                rd_port_n = win;
            end
        end else begin
            burst_cnt_n = '0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            prio      <= 1'b0;
            owner     <= 1'b0;
            burst_cnt <= '0;
            rd_pend   <= 1'b0;
            rd_port   <= 1'b0;
        end else begin
            prio      <= prio_n;
            owner     <= owner_n;
            burst_cnt <= burst_cnt_n;
            rd_pend   <= rd_pend_n;
            rd_port   <= rd_port_n;
        end
    end

    // SRAM pin drive: winner's request when granted, idle values otherwise
    always_comb begin
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_addr = '0;
        sram_d    = '0;
        if (gnt0) begin
            sram_cen  = 1'b0;
            sram_wen  = ~p0_we;
            sram_addr = p0_addr;
            sram_d    = p0_wdata;
        end else if (gnt1) begin
            sram_cen  = 1'b0;
            sram_wen  = ~p1_we;
            sram_addr = p1_addr;
            sram_d    = p1_wdata;
        end
    end

    // Read return: the pending read is steered to its issuer; reset held in
    // the return cycle suppresses the response.
    always_comb begin
        p0_gnt    = gnt0;
        p1_gnt    = gnt1;
        p0_rvalid = rd_pend && !rst && (rd_port == 1'b0);
        p1_rvalid = rd_pend && !rst && (rd_port == 1'b1);
        p0_rdata  = p0_rvalid ? sram_q : '0;
        p1_rdata  = p1_rvalid ? sram_q : '0;
    end

endmodule

// File: tb/tb_sw_sram_arbiter.sv
// tb_sw_sram_arbiter: directed and randomized stimulus for sw_sram_arbiter
// with a behavioural SRAM, a reference arbitration model and a read-data
// scoreboard checked by an independent monitor.
module tb_sw_sram_arbiter;

    localparam int WW = 128;
    localparam int AW = 11;
    localparam int MB = 8;

    typedef struct {
        int            cyc;
        logic [WW-1:0] data;
    } rd_entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req = 1'b0, p0_we = 1'b0, p0_lock = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [WW-1:0] p0_wdata = '0;
    logic          p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [WW-1:0] p1_wdata = '0;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [WW-1:0] p0_rdata, p1_rdata;
    logic          sram_cen, sram_wen;
    logic [AW-1:0] sram_addr;
    logic [WW-1:0] sram_d;
    logic [WW-1:0] sram_q = '0;

    logic [WW-1:0] sram_mem [2**AW];
    logic [WW-1:0] ref_mem  [2**AW];

    int n_compared = 0;
    int n_mismatch = 0;
    int cyc = 0;

    int m_prio = 0;
    int m_owner = 0;
    int m_streak = 0;
    rd_entry_t q0[$];
    rd_entry_t q1[$];

    sw_sram_arbiter #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_d(sram_d),
        .sram_q(sram_q)
    );

    always #5 clk = ~clk;

    // Both memories start with the same address-derived pattern
    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            sram_mem[i] = {4{32'(i) ^ 32'h5A5A_0000}};
            ref_mem[i]  = {4{32'(i) ^ 32'h5A5A_0000}};
        end
    end

    // Behavioural single-port SRAM with one-cycle read latency
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) sram_mem[sram_addr] <= sram_d;
            else           sram_q <= sram_mem[sram_addr];
        end
    end

    task automatic check_output(input string name, input logic [WW-1:0] actual, input logic [WW-1:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s @cycle %0d: got %h expected %h", name, cyc, actual, expected);
        end
    endtask

    // Reference model: decides the winner from the arbitration rules, checks
    // grants and SRAM pins, and queues the data each granted read must return.
    always @(negedge clk) begin
        int            w;
        logic          e_cen, e_wen;
        logic [AW-1:0] e_addr;
        logic [WW-1:0] e_d;
        logic          own_lock;
        cyc++;
        w = -1;
        if (rst) begin
            m_prio = 0;
            m_owner = 0;
            m_streak = 0;
            q0.delete();
            q1.delete();
        end else begin
            if (p0_req && p1_req) begin
                own_lock = (m_owner == 1) ? p1_lock : p0_lock;
                w = (own_lock && m_streak < MB) ? m_owner : m_prio;
            end else if (p0_req) begin
                w = 0;
            end else if (p1_req) begin
                w = 1;
            end
            if (w < 0) begin
                m_streak = 0;
            end else begin
                m_streak = (w == m_owner && m_streak > 0) ? m_streak + 1 : 1;
                m_owner = w;
                m_prio = 1 - w;
            end
        end
        e_cen = 1'b1; e_wen = 1'b1; e_addr = '0; e_d = '0;
        if (w == 0) begin
            e_cen = 1'b0; e_wen = ~p0_we; e_addr = p0_addr; e_d = p0_wdata;
            if (p0_we) ref_mem[p0_addr] = p0_wdata;
            else       q0.push_back('{cyc, ref_mem[p0_addr]});
        end else if (w == 1) begin
            e_cen = 1'b0; e_wen = ~p1_we; e_addr = p1_addr; e_d = p1_wdata;
            if (p1_we) ref_mem[p1_addr] = p1_wdata;
            else       q1.push_back('{cyc, ref_mem[p1_addr]});
        end
        check_output("p0_gnt", WW'(p0_gnt), WW'(w == 0));
        check_output("p1_gnt", WW'(p1_gnt), WW'(w == 1));
        check_output("sram_cen", WW'(sram_cen), WW'(e_cen));
        check_output("sram_wen", WW'(sram_wen), WW'(e_wen));
        check_output("sram_addr", WW'(sram_addr), WW'(e_addr));
        check_output("sram_d", sram_d, e_d);
    end

    // Monitor: a read queued last cycle must appear now; otherwise rvalid=0, rdata=0
    always begin
        @(negedge clk);
        #2;
        if (q0.size() > 0 && q0[0].cyc == cyc - 1) begin
            check_output("p0_rvalid", WW'(p0_rvalid), WW'(1));
            check_output("p0_rdata", p0_rdata, q0[0].data);
            void'(q0.pop_front());
        end else begin
            check_output("p0_rvalid_idle", WW'(p0_rvalid), WW'(0));
            check_output("p0_rdata_idle", p0_rdata, WW'(0));
        end
        if (q1.size() > 0 && q1[0].cyc == cyc - 1) begin
            check_output("p1_rvalid", WW'(p1_rvalid), WW'(1));
            check_output("p1_rdata", p1_rdata, q1[0].data);
            void'(q1.pop_front());
        end else begin
            check_output("p1_rvalid_idle", WW'(p1_rvalid), WW'(0));
            check_output("p1_rdata_idle", p1_rdata, WW'(0));
        end
    end

    task automatic apply_stimulus(input logic r0, input logic w0, input logic l0, input logic [AW-1:0] a0, input logic [WW-1:0] d0,
                                  input logic r1, input logic w1, input logic l1, input logic [AW-1:0] a1, input logic [WW-1:0] d1);
        p0_req = r0; p0_we = w0; p0_lock = l0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_lock = l1; p1_addr = a1; p1_wdata = d1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WW-1:0] a5;
        logic          g0_last, g1_last, seen;
        a5 = {16{8'hA5}};

        // Reset held with both ports requesting
        rst = 1'b1;
        apply_stimulus(1, 0, 0, 11'h001, '0, 1, 0, 0, 11'h002, '0);
        repeat (3) step();
        rst = 1'b0;
        step();

        // Write from port 0, then read of the same word from port 1
        apply_stimulus(1, 1, 0, 11'h010, a5, 0, 0, 0, '0, '0);
        step();
        apply_stimulus(0, 0, 0, '0, '0, 1, 0, 0, 11'h010, '0);
        step();
        apply_stimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        @(negedge clk);
        #3;
        check_output("wr_rd_p1_rdata", p1_rdata, a5);
        step();

        // Contention without lock
        apply_stimulus(1, 0, 0, 11'h020, '0, 1, 0, 0, 11'h030, '0);
        repeat (6) step();
        apply_stimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        step();

        // Burst lock held by port 1 against a continuously waiting port 0
        apply_stimulus(0, 0, 0, '0, '0, 1, 0, 1, 11'h031, '0);
        step();
        apply_stimulus(1, 0, 0, 11'h021, '0, 1, 0, 1, 11'h031, '0);
        repeat (12) step();
        p1_lock = 1'b0;
        repeat (4) step();
        apply_stimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        step();

        // Lock with no competitor, then port 1 joins
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1, 1'($urandom_range(0, 1)), 1, 11'($urandom_range(0, 15)),
                           {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, '0, '0);
            step();
        end
        apply_stimulus(1, 0, 1, 11'h005, '0, 1, 0, 0, 11'h006, '0);
        seen = 1'b0;
        for (int i = 0; i < MB + 1 && !seen; i++) begin
            @(negedge clk);
            seen = p1_gnt;
            step();
        end
        check_output("lock_waiter_granted", WW'(seen), WW'(1));
        apply_stimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        step();

        // Reset in the cycle after a read grant
        apply_stimulus(1, 0, 0, 11'h040, '0, 0, 0, 0, '0, '0);
        step();
        rst = 1'b1;
        apply_stimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        @(negedge clk);
        #3;
        check_output("rst_mid_read_p0_rvalid", WW'(p0_rvalid), WW'(0));
        check_output("rst_mid_read_cen", WW'(sram_cen), WW'(1));
        step();
        rst = 1'b0;
        step();

        // Randomized traffic; a request is held until it is granted
        g0_last = 1'b0;
        g1_last = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!p0_req || g0_last) begin
                p0_req = ($urandom_range(0, 3) != 0);
                p0_we = 1'($urandom_range(0, 1));
                p0_lock = ($urandom_range(0, 3) == 0);
                p0_addr = 11'($urandom_range(0, 15));
                p0_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!p1_req || g1_last) begin
                p1_req = ($urandom_range(0, 3) != 0);
                p1_we = 1'($urandom_range(0, 1));
                p1_lock = ($urandom_range(0, 3) == 0);
                p1_addr = 11'($urandom_range(0, 15));
                p1_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            g0_last = p0_gnt;
            g1_last = p1_gnt;
            step();
        end
        rst = 1'b0;
        apply_stimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
